multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle control FSM for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the datapath selects, including the immediate-format select consumed by the immediate generator, and handshakes with the shared instruction/data memory port. It also counts retired instructions and traps on unsupported opcodes.

## Interface
Parameters:
- none

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- inst_code  in  32  instruction register contents; valid from DECODE onward
- mem_ready  in  1  memory completes the pending request this cycle
- br_taken  in  1  ALU branch-compare result; valid in EXEC
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  write request (stores only)
- mem_is_fetch  out  1  memory address select: 1 = PC, 0 = ALU result
- ir_we  out  1  load instruction register from memory read data
- pc_we  out  1  update PC; asserted exactly once per retired instruction
- pc_sel  out  2  next-PC source: 0 = PC+4, 1 = PC+imm, 2 = (ALU result) & ~1
- reg_we  out  1  register file write of rd
- wb_sel  out  2  writeback source: 0 = ALU, 1 = memory data, 2 = PC+4, 3 = imm
- alu_a_sel  out  1  ALU A: 0 = rs1, 1 = PC
- alu_b_sel  out  1  ALU B: 0 = rs2, 1 = imm
- imm_type  out  3  immediate format: 0 = I, 1 = S, 2 = B, 3 = U, 4 = J, 5 = SHAMT, 7 = none
- state_o  out  3  current state, for debug
- illegal  out  1  sticky trap flag
- instret  out  32  retired-instruction count

## Operation
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 7. Only the state register, illegal and instret are registered; all other outputs are combinational from state and inst_code.
- Outputs not listed for a state are 0. imm_type is 7 in FETCH and TRAP.
- FETCH:
  - Drive mem_req = 1, mem_is_fetch = 1.
  - On mem_ready: ir_we = 1, go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - Decode opcode inst_code[6:0].
  - Legal opcodes go to EXEC. Legal set: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Any other opcode: go to TRAP and set illegal.
- imm_type by opcode, driven in DECODE through WB:
  - load and JALR: I.
  - 0010011: SHAMT when funct3 is 001 or 101, else I.
  - store: S. branch: B. LUI and AUIPC: U. JAL: J. R-type: 7.
- EXEC, per opcode:
  - R-type: a = rs1, b = rs2. Go to WB.
  - I-ALU, load, store: b = imm. I-ALU goes to WB; load and store go to MEM.
  - Branch: a = rs1, b = rs2; pc_we = 1; pc_sel = br_taken ? 1 : 0. Go to FETCH; instruction retires here.
  - AUIPC: a = PC, b = imm. JAL, JALR, LUI: no ALU requirement. All four go to WB.
- MEM:
  - Drive mem_req = 1, mem_is_fetch = 0, alu_b_sel = 1; mem_we = 1 for stores.
  - Wait for mem_ready.
  - Load: go to WB.
  - Store: on mem_ready, pc_we = 1, pc_sel = 0, go to FETCH (retires).
- WB: reg_we = 1 and pc_we = 1, then go to FETCH. Per opcode:
  - R-type, I-ALU, AUIPC: wb_sel = 0, pc_sel = 0. ALU selects are held as in EXEC.
  - Load: wb_sel = 1, pc_sel = 0.
  - LUI: wb_sel = 3, pc_sel = 0.
  - JAL: wb_sel = 2, pc_sel = 1.
  - JALR: wb_sel = 2, pc_sel = 2, alu_b_sel = 1.
- TRAP: terminal. All outputs are 0 except illegal = 1 and state_o = 7. Only reset leaves TRAP.
- instret increments by 1 on every cycle where pc_we = 1. It wraps from 0xFFFFFFFF to 0.

## Timing
- While reset is high at a rising edge: next state = FETCH, illegal = 0, instret = 0.
- During any cycle with reset high, combinational outputs are forced to 0 and imm_type to 7.
- The first cycle after reset deasserts is FETCH with mem_req = 1.
- Latency with mem_ready = 1 on the first request cycle:
  - branch: 3 cycles
  - R-type, I-ALU, LUI, AUIPC, JAL, JALR, store: 4 cycles
  - load: 5 cycles
  - Each memory wait cycle adds 1.
- Handshake: once asserted, mem_req, mem_we and mem_is_fetch stay constant until the cycle mem_ready = 1. mem_ready is ignored when mem_req = 0.
- Reset while a memory request is pending: the request drops the same cycle; FETCH restarts; no pc_we and no instret change.
- pc_we and reg_we are never asserted in FETCH, DECODE or TRAP.

## Test plan
- Reset, then `add` (0x002081B3) with mem_ready tied 1:
  - states 0, 1, 2, 4
  - reg_we = 1 and pc_we = 1 in cycle 4, wb_sel = 0
  - instret = 1
- Load `lw` (0x0000A103) with mem_ready low for 2 cycles in MEM:
  - MEM lasts 3 cycles with mem_req held, mem_we = 0, mem_is_fetch = 0
  - WB: wb_sel = 1
  - 7 cycles total
- Branch `beq` (0x00208463):
  - br_taken = 1: EXEC shows pc_we = 1, pc_sel = 1, imm_type = 2
  - repeat with br_taken = 0: pc_sel = 0
  - 3 cycles each
- `srai` (0x4030D093): imm_type = 5. `jalr` (0x000080E7): WB shows pc_sel = 2, wb_sel = 2, imm_type = 0.
- Opcode 0x0000007F: DECODE goes to TRAP; illegal = 1 and holds for 20 cycles with mem_req = 0; reset clears illegal and instret.
- Reset asserted during a FETCH wait: mem_req = 0 next cycle, instret unchanged. Separately, preload instret near 0xFFFFFFFF via retirements and check it wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives
// datapath selects and the shared memory handshake, counts retirements and
// traps on unsupported opcodes.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst_code,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_is_fetch,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [2:0]  imm_type,
  output logic [2:0]  state_o,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH,
    C_JAL, C_JALR, C_LUI, C_AUIPC, C_BAD
  } op_class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I     = 3'd0;
  localparam logic [2:0] IMM_S     = 3'd1;
  localparam logic [2:0] IMM_B     = 3'd2;
  localparam logic [2:0] IMM_U     = 3'd3;
  localparam logic [2:0] IMM_J     = 3'd4;
  localparam logic [2:0] IMM_SHAMT = 3'd5;
  localparam logic [2:0] IMM_NONE  = 3'd7;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_IMM  = 2'd3;

  state_t            state_q;
  state_t            state_n;
  op_class_t         op_class;
  logic [2:0]        imm_sel;
  logic              illegal_q;
  logic [CNT_W-1:0]  instret_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_inst_bits;

  assign opcode = inst_code[6:0];
  assign funct3 = inst_code[14:12];
  assign unused_inst_bits = ^{inst_code[31:15], inst_code[11:7]};

  // Classify the opcode held in the instruction register.
  always_comb begin
    op_class = C_BAD;
    case (opcode)
      OP_R:      op_class = C_R;
      OP_IALU:   op_class = C_IALU;
      OP_LOAD:   op_class = C_LOAD;
      OP_STORE:  op_class = C_STORE;
      OP_BRANCH: op_class = C_BRANCH;
      OP_JAL:    op_class = C_JAL;
      OP_JALR:   op_class = C_JALR;
      OP_LUI:    op_class = C_LUI;
      OP_AUIPC:  op_class = C_AUIPC;
      default:   op_class = C_BAD;
    endcase
  end

  // Immediate format for the decoded instruction (shifts use the shamt form).
  always_comb begin
    imm_sel = IMM_NONE;
    case (op_class)
      C_LOAD, C_JALR: imm_sel = IMM_I;
      C_IALU:         imm_sel = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SHAMT : IMM_I;
      C_STORE:        imm_sel = IMM_S;
      C_BRANCH:       imm_sel = IMM_B;
      C_LUI, C_AUIPC: imm_sel = IMM_U;
      C_JAL:          imm_sel = IMM_J;
      default:        imm_sel = IMM_NONE;
    endcase
  end

  // State register plus sticky trap flag and retirement counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_n;
      if (state_n == S_TRAP) begin
        illegal_q <= 1'b1;
      end
      if (pc_we) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  // Next-state and combinational datapath controls.
  always_comb begin
    state_n      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_fetch = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_PLUS4;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    imm_type     = IMM_NONE;

    case (state_q)
      S_FETCH: begin
        mem_req      = 1'b1;
        mem_is_fetch = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_n = S_DECODE;
        end
      end

      S_DECODE: begin
        imm_type = imm_sel;
        state_n  = (op_class == C_BAD) ? S_TRAP : S_EXEC;
      end

      S_EXEC: begin
        imm_type = imm_sel;
        case (op_class)
          C_R: begin
            state_n = S_WB;
          end
          C_IALU: begin
            alu_b_sel = 1'b1;
            state_n   = S_WB;
          end
          C_LOAD, C_STORE: begin
            alu_b_sel = 1'b1;
            state_n   = S_MEM;
          end
          C_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = br_taken ? PC_IMM : PC_PLUS4;
            state_n = S_FETCH;
          end
          C_AUIPC: begin
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
            state_n   = S_WB;
          end
          C_JAL, C_JALR, C_LUI: begin
            state_n = S_WB;
          end
          default: begin
            state_n = S_TRAP;
          end
        endcase
      end

      S_MEM: begin
        imm_type  = imm_sel;
        mem_req   = 1'b1;
        alu_b_sel = 1'b1;
        mem_we    = (op_class == C_STORE);
        if (mem_ready) begin
          case (op_class)
            C_LOAD:  state_n = S_WB;
            C_STORE: begin
              pc_we   = 1'b1;
              pc_sel  = PC_PLUS4;
              state_n = S_FETCH;
            end
            default: state_n = S_TRAP;
          endcase
        end
      end

      S_WB: begin
        imm_type = imm_sel;
        reg_we   = 1'b1;
        pc_we    = 1'b1;
        state_n  = S_FETCH;
        case (op_class)
          C_R: begin
            wb_sel = WB_ALU;
          end
          C_IALU: begin
            wb_sel    = WB_ALU;
            alu_b_sel = 1'b1;
          end
          C_AUIPC: begin
            wb_sel    = WB_ALU;
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
          end
          C_LOAD: begin
            wb_sel = WB_MEM;
          end
          C_LUI: begin
            wb_sel = WB_IMM;
          end
          C_JAL: begin
            wb_sel = WB_PC4;
            pc_sel = PC_IMM;
          end
          C_JALR: begin
            wb_sel    = WB_PC4;
            pc_sel    = PC_ALU;
            alu_b_sel = 1'b1;
          end
          default: begin
            wb_sel = WB_ALU;
          end
        endcase
      end

      S_TRAP: begin
        state_n = S_TRAP;
      end

      default: begin
        state_n = S_FETCH;
      end
    endcase

    // Nothing reaches the datapath or memory while reset is held.
    if (reset) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_is_fetch = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = PC_PLUS4;
      reg_we       = 1'b0;
      wb_sel       = WB_ALU;
      alu_a_sel    = 1'b0;
      alu_b_sel    = 1'b0;
      imm_type     = IMM_NONE;
    end
  end

  assign state_o = state_q;
  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule
